dct_butterfly_feed: RTL and testbench
=====================================

DCT_BUTTERFLY_FEED -- requirements
Module: dct_butterfly_feed

Interface
REQ-001 Parameter PHASE_LEN, default 6, is the number of cycles each X0..X3 phase is held; legal range 6..15.
REQ-002 sys_clk  input  1  clock; all state updates on the rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 pixel_i  input  8  unsigned pixel sample, row-serial, sample 0 first.
REQ-005 pixel_vld_i  input  1  pixel_i valid; a sample is accepted when pixel_vld_i and pixel_rdy_o are both 1.
REQ-006 pixel_rdy_o  output  1  capture buffer can accept a sample.
REQ-007 X0, X1, X2, X3  output  12 each  signed butterfly operands for the DA stage.
REQ-008 DA_start  output  1  one-cycle pulse marking the first cycle of a new X0..X3 set.
REQ-009 phase_o  output  1  0 = even (sum) set, 1 = odd (difference) set.
REQ-010 row_idx_o  output  3  index of the row currently presented on X0..X3.

Function
REQ-011 Each accepted sample SHALL be level-shifted to the 9-bit signed value s = pixel_i - 128.
REQ-012 The capture buffer SHALL store s into slot cap_cnt (0..7), and cap_cnt SHALL increment per accepted sample.
REQ-013 On the 8th accepted sample, cap_cnt SHALL wrap to 0 and cap_full SHALL be set.
REQ-014 pixel_rdy_o SHALL equal !cap_full.
REQ-015 No sample SHALL be accepted while cap_full = 1.
REQ-016 The FSM SHALL have the states IDLE, EVEN and ODD, with a 4-bit phase counter ph_cnt.
REQ-017 Transfer condition: cap_full = 1 and either (state = IDLE) or (state = ODD and ph_cnt = PHASE_LEN-1).
REQ-018 On transfer, the 8 slots SHALL be copied to the work register, cap_full SHALL clear and the state SHALL go to EVEN.
REQ-019 On transfer, ph_cnt SHALL be set to 0.
REQ-020 On transfer, the X outputs SHALL be loaded with the even set: X0=s0+s7, X1=s1+s6, X2=s2+s5, X3=s3+s4.
REQ-021 In EVEN, when ph_cnt = PHASE_LEN-1, the state SHALL go to ODD and ph_cnt SHALL be set to 0.
REQ-022 On that EVEN-to-ODD step, the X outputs SHALL be loaded with the odd set: X0=s0-s7, X1=s1-s6, X2=s2-s5, X3=s3-s4.
REQ-023 In ODD, when ph_cnt = PHASE_LEN-1 without a transfer, the state SHALL go to IDLE.
REQ-024 In ODD, when ph_cnt = PHASE_LEN-1 with a transfer, the state SHALL go directly to EVEN for back-to-back rows with no gap cycle.
REQ-025 In all other cycles, ph_cnt SHALL increment in EVEN and ODD and SHALL hold in IDLE.
REQ-026 DA_start SHALL be registered and SHALL be 1 exactly in the first cycle in which each new X set is visible.
REQ-027 DA_start SHALL pulse exactly twice per row, PHASE_LEN cycles apart.
REQ-028 X0..X3 SHALL hold their values for the whole phase, and SHALL keep their last values in IDLE.
REQ-029 Arithmetic: operands SHALL be sign-extended 9 to 12 bits before add or subtract; no saturation (sum range -256..254, difference range -255..255).
REQ-030 phase_o SHALL update together with X0..X3.
REQ-031 row_idx_o SHALL increment on each ODD exit, wrapping from 7 to 0.
REQ-032 A sample may be accepted in the same cycle as a transfer only if cap_full was 0 at the start of that cycle; in practice none is, because rdy is low.
REQ-033 Latency: if the 8th sample is accepted in cycle N and the FSM is IDLE, DA_start SHALL be 1 in cycle N+2 (even set) and in cycle N+2+PHASE_LEN (odd set).

Reset
REQ-034 While sys_rst_n = 0: state = IDLE; cap_cnt = 0; ph_cnt = 0; row_idx_o = 0.
REQ-035 While sys_rst_n = 0: cap_full = 0, so pixel_rdy_o = 1.
REQ-036 While sys_rst_n = 0: X0..X3 = 0, DA_start = 0, phase_o = 0, and the capture and work registers = 0.
REQ-037 Reset asserted mid-row SHALL discard partially captured samples and any in-progress phases; no DA_start SHALL follow the release of reset until 8 new samples are accepted.

Verification
REQ-038 Ramp pixels 0..7, then idle -> even X0..X3 = -249 each, DA_start in cycle N+2; odd X = -7, -5, -3, -1, DA_start 6 cycles later; row_idx_o goes 0 -> 1 at ODD exit.
REQ-039 Eight pixels of 255 -> even X = 254 (12'h0FE) on all four; odd X = 0 on all four.
REQ-040 Eight pixels of 0 -> even X = -256 (12'hF00); odd X = 0.
REQ-041 16 samples streamed with pixel_vld_i held 1 -> pixel_rdy_o low from the 8th sample until transfer; the second row's EVEN DA_start occurs exactly PHASE_LEN cycles after the first row's ODD DA_start; 4 DA_start pulses in total.
REQ-042 Reset asserted after 5 samples, then 8 samples of 128 -> only the post-reset row is emitted: X = 0 in both phases, row_idx_o = 0 at the first DA_start.
REQ-043 PHASE_LEN = 15 back-to-back rows -> DA_start spacing is always 15 cycles; 9 rows produce row_idx_o wrapping 7 -> 0.

Source files
------------

// File: rtl/dct_butterfly_feed.sv
// Row capture buffer and even/odd butterfly feeder for an 8-point DA DCT.
// Collects 8 level-shifted samples, then presents the sum set and the
// difference set on X0..X3, each held for PHASE_LEN cycles.
module dct_butterfly_feed #(
  parameter int unsigned PHASE_LEN = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         pixel_i,
  input  logic               pixel_vld_i,
  output logic               pixel_rdy_o,
  output logic signed [11:0] X0,
  output logic signed [11:0] X1,
  output logic signed [11:0] X2,
  output logic signed [11:0] X3,
  output logic               DA_start,
  output logic               phase_o,
  output logic [2:0]         row_idx_o
);

  localparam int unsigned SW  = 9;   // level-shifted sample width
  localparam int unsigned XW  = 12;  // butterfly operand width
  localparam int unsigned PCW = 4;   // phase counter width
  localparam int unsigned NS  = 8;   // samples per row
  localparam logic [PCW-1:0] PH_LAST = PCW'(PHASE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } state_t;

  // Capture side
  logic signed [SW-1:0] r_cap [NS];
  logic signed [SW-1:0] r_work [NS];
  logic [2:0]           r_cap_cnt;
  logic                 r_cap_full;
  logic                 w_accept;
  logic signed [SW-1:0] w_shift;

  // Sequencer
  state_t         r_state;
  state_t         w_state_nxt;
  logic [PCW-1:0] r_ph_cnt;
  logic [PCW-1:0] w_ph_cnt_nxt;
  logic           w_ph_last;
  logic           w_load_even;
  logic           w_load_odd;
  logic           w_row_adv;
  logic           w_xfer;

  // Output registers
  logic signed [XW-1:0] r_x0, r_x1, r_x2, r_x3;
  logic                 r_da_start;
  logic                 r_phase;
  logic [2:0]           r_row_idx;

  // Butterfly operands
  logic signed [XW-1:0] w_even0, w_even1, w_even2, w_even3;
  logic signed [XW-1:0] w_odd0, w_odd1, w_odd2, w_odd3;

  function automatic logic signed [XW-1:0] sext(input logic signed [SW-1:0] v);
    return {{(XW - SW){v[SW-1]}}, v};
  endfunction

  assign w_accept    = pixel_vld_i & ~r_cap_full;
  assign w_shift     = $signed({1'b0, pixel_i} - 9'd128);
  assign pixel_rdy_o = ~r_cap_full;
  assign w_ph_last   = (r_ph_cnt == PH_LAST);
  assign w_xfer      = w_load_even;

  // Capture buffer: fills slots 0..7, then blocks until the row is transferred
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NS; i++) r_cap[i] <= '0;
      r_cap_cnt  <= '0;
      r_cap_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cap[r_cap_cnt] <= w_shift;
        r_cap_cnt        <= r_cap_cnt + 3'd1;
        if (r_cap_cnt == 3'd7) r_cap_full <= 1'b1;
      end else if (w_xfer) begin
        r_cap_full <= 1'b0;
      end
    end
  end

  // Work register: snapshot of the row being fed to the DA stage
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NS; i++) r_work[i] <= '0;
    end else if (w_xfer) begin
      for (int i = 0; i < NS; i++) r_work[i] <= r_cap[i];
    end
  end

  // Sequencer state and phase counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_ph_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph_cnt <= w_ph_cnt_nxt;
    end
  end

  // Next state: IDLE -> EVEN on a full buffer, EVEN -> ODD, ODD -> EVEN/IDLE
  always_comb begin
    w_state_nxt  = r_state;
    w_ph_cnt_nxt = r_ph_cnt;
    w_load_even  = 1'b0;
    w_load_odd   = 1'b0;
    w_row_adv    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cap_full) begin
          w_state_nxt  = ST_EVEN;
          w_ph_cnt_nxt = '0;
          w_load_even  = 1'b1;
        end
      end
      ST_EVEN: begin
        if (w_ph_last) begin
          w_state_nxt  = ST_ODD;
          w_ph_cnt_nxt = '0;
          w_load_odd   = 1'b1;
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + 4'd1;
        end
      end
      ST_ODD: begin
        if (w_ph_last) begin
          w_row_adv    = 1'b1;
          w_ph_cnt_nxt = '0;
          if (r_cap_full) begin
            // next row already captured: no gap cycle
            w_state_nxt = ST_EVEN;
            w_load_even = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_ph_cnt_nxt = '0;
      end
    endcase
  end

  // Sums come straight from the capture buffer, since the work copy lands
  // on the same edge that loads them; differences come from the work copy.
  assign w_even0 = sext(r_cap[0]) + sext(r_cap[7]);
  assign w_even1 = sext(r_cap[1]) + sext(r_cap[6]);
  assign w_even2 = sext(r_cap[2]) + sext(r_cap[5]);
  assign w_even3 = sext(r_cap[3]) + sext(r_cap[4]);
  assign w_odd0  = sext(r_work[0]) - sext(r_work[7]);
  assign w_odd1  = sext(r_work[1]) - sext(r_work[6]);
  assign w_odd2  = sext(r_work[2]) - sext(r_work[5]);
  assign w_odd3  = sext(r_work[3]) - sext(r_work[4]);

  // Operand, phase, start-pulse and row-index registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_x3       <= '0;
      r_da_start <= 1'b0;
      r_phase    <= 1'b0;
      r_row_idx  <= '0;
    end else begin
      r_da_start <= w_load_even | w_load_odd;
      if (w_load_even) begin
        r_x0    <= w_even0;
        r_x1    <= w_even1;
        r_x2    <= w_even2;
        r_x3    <= w_even3;
        r_phase <= 1'b0;
      end else if (w_load_odd) begin
        r_x0    <= w_odd0;
        r_x1    <= w_odd1;
        r_x2    <= w_odd2;
        r_x3    <= w_odd3;
        r_phase <= 1'b1;
      end
      if (w_row_adv) r_row_idx <= r_row_idx + 3'd1;
    end
  end

  assign X0        = r_x0;
  assign X1        = r_x1;
  assign X2        = r_x2;
  assign X3        = r_x3;
  assign DA_start  = r_da_start;
  assign phase_o   = r_phase;
  assign row_idx_o = r_row_idx;

endmodule

// File: tb/tb_dct_butterfly_feed.sv
// Bench for dct_butterfly_feed: two instances (PHASE_LEN 6 and 15) driven
// from one stimulus sequence; output events are compared with a row-level model.
module tb_dct_butterfly_feed;

  localparam int unsigned PL_A = 6;
  localparam int unsigned PL_B = 15;

  typedef struct {
    int cyc; int da; int ph; int x0; int x1; int x2; int x3; int row;
  } ev_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] pixel_i   = '0;
  logic       vld       = 1'b0;
  int         sel       = 0;

  logic vld_a, vld_b, rdy_a, rdy_b, da_a, da_b, ph_a, ph_b;
  logic signed [11:0] a_x0, a_x1, a_x2, a_x3, b_x0, b_x1, b_x2, b_x3;
  logic [2:0] row_a, row_b;

  assign vld_a = vld && (sel == 0);
  assign vld_b = vld && (sel == 1);

  dct_butterfly_feed #(.PHASE_LEN(PL_A)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pixel_i(pixel_i),
    .pixel_vld_i(vld_a), .pixel_rdy_o(rdy_a),
    .X0(a_x0), .X1(a_x1), .X2(a_x2), .X3(a_x3),
    .DA_start(da_a), .phase_o(ph_a), .row_idx_o(row_a));

  dct_butterfly_feed #(.PHASE_LEN(PL_B)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pixel_i(pixel_i),
    .pixel_vld_i(vld_b), .pixel_rdy_o(rdy_b),
    .X0(b_x0), .X1(b_x1), .X2(b_x2), .X3(b_x3),
    .DA_start(da_b), .phase_o(ph_b), .row_idx_o(row_b));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  ev_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];

  // Log every start pulse and every operand/phase change outside reset
  logic signed [11:0] pa0, pa1, pa2, pa3, pb0, pb1, pb2, pb3;
  logic ppa, ppb;
  always @(negedge sys_clk) begin
    if (sys_rst_n && (da_a || a_x0 != pa0 || a_x1 != pa1 || a_x2 != pa2 ||
                      a_x3 != pa3 || ph_a != ppa))
      obs_a.push_back('{cyc, int'(da_a), int'(ph_a), int'(a_x0), int'(a_x1),
                        int'(a_x2), int'(a_x3), int'(row_a)});
    if (sys_rst_n && (da_b || b_x0 != pb0 || b_x1 != pb1 || b_x2 != pb2 ||
                      b_x3 != pb3 || ph_b != ppb))
      obs_b.push_back('{cyc, int'(da_b), int'(ph_b), int'(b_x0), int'(b_x1),
                        int'(b_x2), int'(b_x3), int'(row_b)});
    pa0 <= a_x0; pa1 <= a_x1; pa2 <= a_x2; pa3 <= a_x3; ppa <= ph_a;
    pb0 <= b_x0; pb1 <= b_x1; pb2 <= b_x2; pb3 <= b_x3; ppb <= ph_b;
  end

  // Row-level model state
  int m_s[8];
  int m_cnt  = 0;
  int m_full = -1000;   // cycle in which the 8th sample was accepted
  int m_even = -1000;   // cycle of the last even-set start
  int m_odd  = -1000;   // cycle of the last odd-set start
  int m_rows = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_full = -1000; m_even = -1000; m_odd = -1000; m_rows = 0;
  endtask

  // A full row: the even set starts 2 cycles after the last sample, but not
  // before the previous row's odd phase has run its course.
  task automatic model_row(input int t);
    int pl, e;
    ev_t ev;
    pl = (sel == 1) ? int'(PL_B) : int'(PL_A);
    e  = (t + 2 > m_odd + pl) ? t + 2 : m_odd + pl;
    ev = '{e, 1, 0, m_s[0] + m_s[7], m_s[1] + m_s[6], m_s[2] + m_s[5],
           m_s[3] + m_s[4], m_rows % 8};
    if (sel == 1) exp_b.push_back(ev); else exp_a.push_back(ev);
    ev = '{e + pl, 1, 1, m_s[0] - m_s[7], m_s[1] - m_s[6], m_s[2] - m_s[5],
           m_s[3] - m_s[4], m_rows % 8};
    if (sel == 1) exp_b.push_back(ev); else exp_a.push_back(ev);
    m_full = t; m_even = e; m_odd = e + pl; m_rows++; m_cnt = 0;
  endtask

  // Present one sample (called at a falling edge) and hold it until accepted
  task automatic send(input int pix);
    int t, guard;
    bit done;
    logic r_obs, r_exp;
    pixel_i = 8'(pix);
    vld = 1'b1;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      t = cyc;
      r_obs = (sel == 1) ? rdy_b : rdy_a;
      r_exp = !(t > m_full && t < m_even);
      chk($sformatf("rdy@%0d", t), r_obs, r_exp);
      if (r_obs === 1'b1) begin
        done = 1'b1;
        m_s[m_cnt] = pix - 128;
        m_cnt++;
        if (m_cnt == 8) model_row(t);
      end
      @(negedge sys_clk);
      guard++;
      if (!done && guard > 300) begin
        n_err++;
        $error("FAIL rdy_timeout observed=0 expected=1");
        done = 1'b1;
      end
    end
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    vld = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_rdy_a", rdy_a, 1);
    chk("rst_rdy_b", rdy_b, 1);
    chk("rst_da_a", da_a, 0);
    chk("rst_da_b", da_b, 0);
    chk("rst_x0_a", a_x0, 0);
    chk("rst_x3_a", a_x3, 0);
    chk("rst_x0_b", b_x0, 0);
    chk("rst_phase_a", ph_a, 0);
    chk("rst_row_a", row_a, 0);
    chk("rst_row_b", row_b, 0);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cmp_q(input int which);
    ev_t o[$], e[$];
    if (which == 0) begin o = obs_a; e = exp_a; end
    else begin o = obs_b; e = exp_b; end
    chk($sformatf("n_events_%0d", which), o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      chk($sformatf("d%0d_ev%0d_cyc", which, i), o[i].cyc, e[i].cyc);
      chk($sformatf("d%0d_ev%0d_da", which, i), o[i].da, e[i].da);
      chk($sformatf("d%0d_ev%0d_phase", which, i), o[i].ph, e[i].ph);
      chk($sformatf("d%0d_ev%0d_x0", which, i), o[i].x0, e[i].x0);
      chk($sformatf("d%0d_ev%0d_x1", which, i), o[i].x1, e[i].x1);
      chk($sformatf("d%0d_ev%0d_x2", which, i), o[i].x2, e[i].x2);
      chk($sformatf("d%0d_ev%0d_x3", which, i), o[i].x3, e[i].x3);
      chk($sformatf("d%0d_ev%0d_row", which, i), o[i].row, e[i].row);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    idle(2);

    // Ramp 0..7: even all -249, odd -7,-5,-3,-1
    for (int i = 0; i < 8; i++) send(i);
    idle(25);

    // All-255 and all-0 rows: extremes of the sum range
    for (int i = 0; i < 8; i++) send(255);
    idle(25);
    for (int i = 0; i < 8; i++) send(0);
    idle(25);

    // 16 samples streamed with valid held: second row waits for the first
    for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)));
    idle(35);

    // Three more streamed rows of random data
    for (int i = 0; i < 24; i++) send(int'($urandom_range(0, 255)));
    idle(45);

    // Reset after a partial row: only the post-reset row may appear
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)));
    do_reset();
    idle(3);
    for (int i = 0; i < 8; i++) send(128);
    idle(25);

    // Long phases, nine back-to-back rows: row index wraps
    do_reset();
    sel = 1;
    for (int i = 0; i < 72; i++) send(int'($urandom_range(0, 255)));
    idle(70);

    cmp_q(0);
    cmp_q(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
